// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with tear-free frame commit.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                    state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [IDX_W-1:0]          idx_r;
    logic [4*NUM_DIGITS-1:0]   pend_r;
    logic [NUM_DIGITS-1:0]     pend_dp_r;
    logic                      pend_valid_r;
    logic [4*NUM_DIGITS-1:0]   disp_r;
    logic [NUM_DIGITS-1:0]     disp_dp_r;
    logic [NUM_DIGITS-1:0]     anode_n_r;
    logic                      dp_n_r;
    logic                      frame_start_r;
    logic [NUM_DIGITS-1:0]     sel_s;
    logic [NUM_DIGITS-1:0]     shown_s;

`ifdef SEG7_LZ_BLANK_EN
    // A digit is shown if it or any higher digit is nonzero or has its point lit; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] shown_mask(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic [NUM_DIGITS-1:0]   dp
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        seen = 1'b0;
        m    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen = seen | (val[4*k +: 4] != 4'h0) | dp[k];
            m[k] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    assign shown_s = shown_mask(disp_r, disp_dp_r);
`else
    assign shown_s = '1;
`endif

    assign sel_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;

    // Scan FSM, buffer commit and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_BLANK;
            cnt_r         <= '0;
            idx_r         <= '0;
            pend_r        <= '0;
            pend_dp_r     <= '0;
            pend_valid_r  <= 1'b0;
            disp_r        <= '0;
            disp_dp_r     <= '0;
            anode_n_r     <= '1;
            dp_n_r        <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            anode_n_r     <= '1;
            dp_n_r        <= 1'b1;
            if (load) begin
                pend_r       <= value_in;
                pend_dp_r    <= dp_in;
                pend_valid_r <= 1'b1;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            if (!en) begin
                state_r <= ST_BLANK;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    ST_BLANK: begin
                        if (cnt_r == BLANK_LAST) begin
                            state_r   <= ST_ON;
                            cnt_r     <= '0;
                            anode_n_r <= ~(sel_s & shown_s);
                            dp_n_r    <= ~disp_dp_r[idx_r];
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (cnt_r == ON_LAST) begin
                            state_r <= ST_BLANK;
                            cnt_r   <= '0;
                            if (idx_r == IDX_LAST) begin
                                idx_r         <= '0;
                                frame_start_r <= 1'b1;
                                // Same-cycle load bypasses the pending buffer so it is not lost.
                                if (load) begin
                                    disp_r       <= value_in;
                                    disp_dp_r    <= dp_in;
                                    pend_valid_r <= 1'b0;
                                end else if (pend_valid_r) begin
                                    disp_r       <= pend_r;
                                    disp_dp_r    <= pend_dp_r;
                                    pend_valid_r <= 1'b0;
                                end else begin
                                    disp_r <= disp_r;
                                end
                            end else begin
                                idx_r <= idx_r + IDX_W'(1);
                            end
                        end else begin
                            cnt_r     <= cnt_r + CNT_W'(1);
                            anode_n_r <= anode_n_r;
                            dp_n_r    <= dp_n_r;
                        end
                    end
                    default: begin
                        state_r <= ST_BLANK;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign bcd_out     = disp_r[{idx_r, 2'b00} +: 4];
    assign anode_n     = anode_n_r;
    assign dp_n        = dp_n_r;
    assign digit_idx   = idx_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: expected digit windows are queued by the stimulus and
// checked by a monitor each time a new anode window opens.
module tb_seg7_scan_ctrl;

    localparam int N   = 4;
    localparam int ONC = 4;
    localparam int BLC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  bcd_out;
    logic [3:0]  anode_n;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_start;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ONC), .BLANK_CYCLES(BLC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
        .bcd_out(bcd_out), .anode_n(anode_n), .dp_n(dp_n), .digit_idx(digit_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dpn;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   prev_dark = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_digit(input int k, input logic [15:0] v, input logic [3:0] dp);
        exp_t       e;
        logic [3:0] one;
        one   = 4'b0001;
        e.an  = ~(one << k);
        e.bcd = v[4*k +: 4];
        e.dpn = ~dp[k];
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
        for (int k = 0; k < N; k++) push_digit(k, v, dp);
    endtask

    task automatic wait_fs(output int at);
        bit found;
        found = 1'b0;
        at = cyc;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (frame_start === 1'b1) begin
                found = 1'b1;
                at = cyc;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_frame_start: got no pulse within 60 cycles, expected one");
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) tick();
    endtask

    // Monitor: each new anode window is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dark = 1'b1;
        end else begin
            if (anode_n !== 4'hF && prev_dark) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_window: got anode_n=%b, expected no window", anode_n);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("win_anode", {28'h0, anode_n}, {28'h0, mon_e.an});
                    check("win_bcd", {28'h0, bcd_out}, {28'h0, mon_e.bcd});
                    check("win_dp_n", {31'h0, dp_n}, {31'h0, mon_e.dpn});
                end
            end
            prev_dark = (anode_n === 4'hF);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int t3;
        rst_n = 1'b0;
        en    = 1'b1;
        tick();
        tick();
        check("rst_anode", {28'h0, anode_n}, 32'hF);
        check("rst_dp_n", {31'h0, dp_n}, 32'h1);
        check("rst_bcd", {28'h0, bcd_out}, 32'h0);
        check("rst_fs", {31'h0, frame_start}, 32'h0);
        check("rst_idx", {30'h0, digit_idx}, 32'h0);

        // Frame 0 shows zeros; 12AB is loaded mid-frame and appears only in frame 1.
        push_frame(16'h0000, 4'b0000);
        rst_n = 1'b1;
        repeat (3) tick();
        load = 1'b1; value_in = 16'h12AB; dp_in = 4'b0100;
        push_frame(16'h12AB, 4'b0100);
        tick();
        load = 1'b0;
        check("hold_before_commit", {28'h0, bcd_out}, 32'h0);

        // Frame 1: two loads, only the last one may reach frame 2.
        wait_fs(t1);
        tick();
        check("fs_one_cycle", {31'h0, frame_start}, 32'h0);
        tick();
        load = 1'b1; value_in = 16'h1111; dp_in = 4'b1111;
        tick();
        load = 1'b0;
        repeat (2) tick();
        load = 1'b1; value_in = 16'h2222; dp_in = 4'b0000;
        push_frame(16'h2222, 4'b0000);
        tick();
        load = 1'b0;

        // Frame 2: load lands exactly on the commit cycle.
        wait_fs(t2);
        check("frame_period", t2 - t1, 32'd24);
        tick();
        repeat (22) tick();
        load = 1'b1; value_in = 16'hBEEF; dp_in = 4'b1000;
        push_digit(0, 16'hBEEF, 4'b1000);
        push_digit(1, 16'hBEEF, 4'b1000);
        push_digit(2, 16'hBEEF, 4'b1000);
        push_digit(2, 16'hBEEF, 4'b1000);
        push_digit(3, 16'hBEEF, 4'b1000);
        tick();
        load = 1'b0;
        check("fs_at_wrap", {31'h0, frame_start}, 32'h1);

        // Frame 3: drop enable during digit 2 ON, then restore.
        repeat (15) tick();
        check("d2_on", {28'h0, anode_n}, 32'hB);
        en = 1'b0;
        tick();
        check("en_off_dark", {28'h0, anode_n}, 32'hF);
        repeat (2) tick();
        check("en_off_still_dark", {28'h0, anode_n}, 32'hF);
        check("en_off_idx_held", {30'h0, digit_idx}, 32'h2);
        en = 1'b1;
        tick();
        check("restore_blank", {28'h0, anode_n}, 32'hF);
        tick();
        check("restore_on", {28'h0, anode_n}, 32'hB);
        drain(40);

        // Frame 4: set pending data, then reset asynchronously during digit 0 ON.
        wait_fs(t3);
        push_digit(0, 16'hBEEF, 4'b1000);
        load = 1'b1; value_in = 16'h1234; dp_in = 4'b0001;
        tick();
        load = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_anode", {28'h0, anode_n}, 32'hF);
        check("mid_rst_dp_n", {31'h0, dp_n}, 32'h1);
        check("mid_rst_bcd", {28'h0, bcd_out}, 32'h0);
        check("mid_rst_idx", {30'h0, digit_idx}, 32'h0);
        check("mid_rst_fs", {31'h0, frame_start}, 32'h0);
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b1;
        drain(120);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
